// File: rtl/hram_pkg.sv
// hram_pkg: shared FSM state, geometry defaults and clog2 helper for the HyperRAM frame DMA.
package hram_pkg;

    typedef enum logic [1:0] {IDLE, CAPTURE, READBACK} state_t;

    localparam int DEF_FRAME_W     = 320;
    localparam int DEF_FRAME_H     = 256;
    localparam int DEF_FRAME_WORDS = DEF_FRAME_W * DEF_FRAME_H;

    // Bits needed to index v distinct values; 0 for v <= 1.
    function automatic int clog2(input longint v);
        int r;
        longint x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hram_buf_ring.sv
// hram_buf_ring: frame buffer ring -- write/read buffer indices, their base addresses and frame_avail.
//   clk, resetn      : clock, asynchronous active-low reset
//   advance          : pulse on the last accepted word of a capture frame
//   wr_buf, wr_base  : buffer being captured into and its first word address
//   rd_buf, rd_base  : last completed capture buffer and its first word address
//   frame_avail      : a capture frame has completed since reset
module hram_buf_ring
    import hram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 22,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int NUM_BUFFERS = 2,
    parameter int BW          = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  advance,
    output logic [BW-1:0]         wr_buf,
    output logic [BW-1:0]         rd_buf,
    output logic [ADDR_WIDTH-1:0] wr_base,
    output logic [ADDR_WIDTH-1:0] rd_base,
    output logic                  frame_avail
);

    // Bases are kept incrementally so no index*FRAME_WORDS multiplier is needed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_buf      <= '0;
            rd_buf      <= '0;
            wr_base     <= '0;
            rd_base     <= '0;
            frame_avail <= 1'b0;
        end else if (advance) begin
            rd_buf      <= wr_buf;
            rd_base     <= wr_base;
            frame_avail <= 1'b1;
            if (wr_buf == BW'(NUM_BUFFERS - 1)) begin
                wr_buf  <= '0;
                wr_base <= '0;
            end else begin
                wr_buf  <= wr_buf + 1'b1;
                wr_base <= wr_base + ADDR_WIDTH'(FRAME_WORDS);
            end
        end
    end

endmodule

// File: rtl/hram_frame_dma.sv
// hram_frame_dma: frame sequencer between the camera pixel FIFO and the HyperRAM SRAM issue port.
//   clk, resetn                  : clock, asynchronous active-low reset
//   enable, mode                 : run request; 0 = capture FIFO->RAM, 1 = readback RAM->out
//   fifo_data/empty/deq          : first-word-fall-through pixel FIFO
//   sram_req/ready/rd/addr/wr_data : request channel, held stable until ready
//   sram_rd_data_vld/rd_data     : read data return
//   out_data/out_valid           : registered readback stream, no backpressure
//   frame_done                   : one-cycle pulse per completed frame
//   frame_avail, wr_buf, rd_buf  : buffer status for the consumer
module hram_frame_dma
    import hram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 22,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int NUM_BUFFERS = 2,
    parameter int MAX_OUTST   = 4,
    localparam int BW = clog2(NUM_BUFFERS < 2 ? 2 : NUM_BUFFERS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_deq,
    output logic                  sram_req,
    input  logic                  sram_ready,
    output logic                  sram_rd,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wr_data,
    input  logic                  sram_rd_data_vld,
    input  logic [DATA_WIDTH-1:0] sram_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  frame_done,
    output logic                  frame_avail,
    output logic [BW-1:0]         wr_buf,
    output logic [BW-1:0]         rd_buf
);

    localparam int CW = clog2(FRAME_WORDS + 1);
    localparam int OW = clog2(MAX_OUTST + 1);

    if (FRAME_WORDS < 2 || NUM_BUFFERS < 1 || MAX_OUTST < 1 ||
        longint'(NUM_BUFFERS) * FRAME_WORDS > (longint'(1) << ADDR_WIDTH)) begin : g_bad_geometry
        $fatal(1, "hram_frame_dma: invalid frame/buffer geometry for ADDR_WIDTH");
    end

    state_t                state;
    state_t                next_run;
    logic [CW-1:0]         word_cnt;
    logic [CW-1:0]         issued;
    logic [CW-1:0]         rcv;
    logic [OW-1:0]         outst;
    logic                  rb_last;
    logic [ADDR_WIDTH-1:0] wr_base;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic                  cap;
    logic                  rb;
    logic                  acc;
    logic                  rd_vld;
    logic                  cap_end;
    logic                  rb_end;

    assign cap          = state == CAPTURE;
    assign rb           = state == READBACK;
    assign sram_req     = cap ? !fifo_empty
                        : rb && issued < CW'(FRAME_WORDS) && outst < OW'(MAX_OUTST);
    assign sram_rd      = rb;
    assign sram_wr_data = cap ? fifo_data : '0;
    assign sram_addr    = rb ? rd_base + ADDR_WIDTH'(issued) : wr_base + ADDR_WIDTH'(word_cnt);
    assign acc          = sram_req && sram_ready;
    assign fifo_deq     = cap && acc;
    // Read data outside readback is stray and must not reach the output.
    assign rd_vld       = rb && sram_rd_data_vld;
    assign cap_end      = fifo_deq && word_cnt == CW'(FRAME_WORDS - 1);
    assign rb_end       = rd_vld && rcv == CW'(FRAME_WORDS - 1);
    // At a frame boundary mode is always allowed to select readback: a capture
    // just completed or a readback was already running, so frame_avail is set.
    assign next_run     = !enable ? IDLE : mode ? READBACK : CAPTURE;

    hram_buf_ring #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .FRAME_WORDS(FRAME_WORDS),
        .NUM_BUFFERS(NUM_BUFFERS),
        .BW         (BW)
    ) u_ring (
        .clk        (clk),
        .resetn     (resetn),
        .advance    (cap_end),
        .wr_buf     (wr_buf),
        .rd_buf     (rd_buf),
        .wr_base    (wr_base),
        .rd_base    (rd_base),
        .frame_avail(frame_avail)
    );

    // rb_last delays the readback frame_done so it lands one cycle after the final out_valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            word_cnt   <= '0;
            issued     <= '0;
            rcv        <= '0;
            outst      <= '0;
            rb_last    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= rd_vld;
            out_data   <= rd_vld ? sram_rd_data : out_data;
            rb_last    <= rb_end;
            frame_done <= cap_end || rb_last;
            case (state)
                IDLE: begin
                    if (enable && (!mode || frame_avail))
                        state <= next_run;
                end
                CAPTURE: begin
                    if (cap_end) begin
                        word_cnt <= '0;
                        state    <= next_run;
                    end else if (fifo_deq) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                READBACK: begin
                    if (rb_end) begin
                        issued <= '0;
                        rcv    <= '0;
                        outst  <= '0;
                        state  <= next_run;
                    end else begin
                        issued <= issued + CW'(acc);
                        rcv    <= rcv + CW'(rd_vld);
                        outst  <= outst + OW'(acc) - OW'(rd_vld);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
